// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and pulses o_tick on the
// last count of each bit period, then wraps to 0. Held at 0 when disabled.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // Counter: cleared on request, when idle, and on every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte in over valid/ready, out on txd as 8N1 (8E1 when
// UART_TX_PARITY_EN is defined). txd and ready are registered. After a frame,
// ready only returns once valid has been seen low, so a byte still presented
// by the producer is never sent twice.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_t     r_state, w_state_d;
  logic [7:0] r_shift, w_shift_d;
  logic [2:0] r_bit_idx, w_bit_idx_d;
  logic       r_ready, w_ready_d;
  logic       r_txd, w_txd_d;
  logic       w_tick;
  logic       w_baud_en;
  logic       w_accept;
`ifdef UART_TX_PARITY_EN
  logic       r_parity, w_parity_d;
`endif

  assign w_accept  = (r_state == IDLE) && r_ready && valid;
  assign w_baud_en = (r_state != IDLE) && (r_state != HOLD);

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_baud_en),
    .i_clr (w_accept),
    .o_tick(w_tick)
  );

  // Next-state, shift/bit-index updates, and next values of the registered outputs.
  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_idx_d = r_bit_idx;
`ifdef UART_TX_PARITY_EN
    w_parity_d  = r_parity;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d   = START;
          w_shift_d   = data;
          w_bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_d  = ^data;
`endif
        end
      end
      START: begin
        if (w_tick) w_state_d = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_d = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            w_state_d   = PARITY;
`else
            w_state_d   = STOP;
`endif
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_d = STOP;
      end
`endif
      STOP: begin
        // Bit index is reused to count stop bits.
        if (w_tick) begin
          if (r_bit_idx == STOP_LAST) begin
            w_bit_idx_d = '0;
            w_state_d   = valid ? HOLD : IDLE;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      HOLD: begin
        if (!valid) w_state_d = IDLE;
      end
      default: begin
        w_state_d   = IDLE;
        w_bit_idx_d = '0;
      end
    endcase

    w_ready_d = (w_state_d == IDLE);

    // Line level is derived from the next state so txd lines up with r_state.
    case (w_state_d)
      START:   w_txd_d = 1'b0;
      DATA:    w_txd_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txd_d = w_parity_d;
`endif
      default: w_txd_d = UART_IDLE_LEVEL;
    endcase
  end

  // State and datapath registers with asynchronous reset to an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_ready   <= 1'b1;
      r_txd     <= UART_IDLE_LEVEL;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_bit_idx <= w_bit_idx_d;
      r_ready   <= w_ready_d;
      r_txd     <= w_txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, captured at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_d;
    end
  end
`endif

  assign ready = r_ready;
  assign txd   = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLK_DIV=4); a second instance covers STOP_BITS=2.
// Honours UART_TX_PARITY_EN when the build defines it.
module tb_uart_tx;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = (10 + PAR) * CLK_DIV;  // one-stop-bit frame length

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic       valid = 1'b0;
  logic       valid2 = 1'b0;
  logic       ready, txd, ready2, txd2;

  int checks = 0;
  int errors = 0;

  bit         rx_en = 1'b0;
  int         rx_ferr = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_DIV  (CLK_DIV),
    .STOP_BITS(1)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .txd  (txd)
  );

  uart_tx #(
    .CLK_DIV  (CLK_DIV),
    .STOP_BITS(2)
  ) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .data (data2),
    .valid(valid2),
    .ready(ready2),
    .txd  (txd2)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected txd in frame cycle k (cycle 0 = first start-bit cycle).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int bi;
    bi = k / CLK_DIV;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (PAR == 1 && bi == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one byte on u_dut and check every txd cycle; data is scrambled after
  // accept to show it is not re-sampled. hold keeps valid high after accept.
  task automatic send_check(input logic [7:0] b, input bit hold, input string tag);
    data  = b;
    valid = 1'b1;
    check($sformatf("%s_rdy_pre", tag), ready, 1'b1);
    step();
    data  = ~b;
    valid = hold;
    check($sformatf("%s_rdy_fall", tag), ready, 1'b0);
    for (int k = 0; k < FL; k++) begin
      check($sformatf("%s_txd%0d", tag, k), txd, exp_bit(b, k));
      if (k == FL - 1) check($sformatf("%s_rdy_last", tag), ready, 1'b0);
      step();
    end
    check($sformatf("%s_rdy_end", tag), ready, !hold);
  endtask

  // Receiver model on u_dut: samples mid-bit at falling edges.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (rx_en && txd === 1'b0) begin
        repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rb[i] = txd;
          if (i < 7) repeat (CLK_DIV) @(negedge clk);
        end
        repeat ((1 + PAR) * CLK_DIV) @(negedge clk);
        if (txd !== 1'b1) rx_ferr++;
        rx_q.push_back(rb);
      end
    end
  end

  initial begin
    int n;
    int got;

    // Reset values.
    #12;
    check("rst_ready", ready, 1'b1);
    check("rst_txd", txd, 1'b1);
    check("rst_ready2", ready2, 1'b1);
    check("rst_txd2", txd2, 1'b1);
    step();
    rst = 1'b0;
    step();
    check("idle_txd", txd, 1'b1);

    // Basic frame 0x61.
    send_check(8'h61, 1'b0, "b61");
    step();
    check("b61_idle_txd", txd, 1'b1);

    // valid held through the end of frame -> HOLD.
    send_check(8'h5A, 1'b1, "hold");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_rdy%0d", i), ready, 1'b0);
      check($sformatf("hold_txd%0d", i), txd, 1'b1);
      step();
    end
    valid = 1'b0;
    step();
    check("hold_rel_rdy", ready, 1'b1);
    check("hold_rel_txd", txd, 1'b1);
    step();
    check("hold_no2nd_txd", txd, 1'b1);

    // Chargen-style producer: 'a'..'z'.
    rx_q.delete();
    rx_en = 1'b1;
    for (int c = 0; c < 26; c++) begin
      data  = 8'(8'h61 + c);
      valid = 1'b1;
      step();
      valid = 1'b0;
      check($sformatf("cg_rdy_fall%0d", c), ready, 1'b0);
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      check_int($sformatf("cg_len%0d", c), n, FL);
    end
    repeat (4) step();
    rx_en = 1'b0;
    check_int("cg_count", rx_q.size(), 26);
    check_int("cg_ferr", rx_ferr, 0);
    for (int i = 0; i < 26; i++) begin
      got = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
      check_int($sformatf("cg_char%0d", i), got, 8'h61 + i);
    end

    // Reset during data bit 3 of 0xFF.
    data  = 8'hFF;
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (17) step();
    check("mid_rdy_busy", ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rdy", ready, 1'b1);
    check("mid_rst_txd", txd, 1'b1);
    step();
    step();
    check("mid_rst_hold_txd", txd, 1'b1);
    rst = 1'b0;
    send_check(8'h55, 1'b0, "post_rst");

    // STOP_BITS=2, data 0x00.
    data2  = 8'h00;
    valid2 = 1'b1;
    step();
    valid2 = 1'b0;
    for (int k = 0; k < (9 + PAR) * CLK_DIV; k++) begin
      check($sformatf("sb2_low%0d", k), txd2, 1'b0);
      step();
    end
    for (int k = 0; k < 2 * CLK_DIV; k++) begin
      check($sformatf("sb2_high%0d", k), txd2, 1'b1);
      check($sformatf("sb2_rdy%0d", k), ready2, 1'b0);
      step();
    end
    check("sb2_rdy_end", ready2, 1'b1);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0, in cycles 36..39.
    step();
    send_check(8'h07, 1'b0, "par07");
    step();
    send_check(8'h03, 1'b0, "par03");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter stage directly downstream of the character generator.
- Accepts one byte per transfer over the data/valid/ready level handshake and shifts it out on a single TX line as 8N1, or 8E1 with the optional feature.
- Drives the board UART pin at a baud rate set by a fixed clock divider.

Parameters:
- CLK_DIV, 868, clock cycles per bit period (100 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  byte to transmit; sampled only on the accept cycle.
- valid  input  1  producer has a byte on data.
- ready  output  1  transmitter idle and able to accept a byte.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset (async, asserted): state=IDLE, ready=1, txd=1, baud counter=0, bit index=0, shift register=0.
- Accept: a rising edge with valid=1 and ready=1 latches data into the shift register. On the next cycle ready=0 and txd=0 (start bit), state=START.
- Handshake rule: ready returns to 1 only when both hold:
  - the last stop bit has completed;
  - valid has been observed low.
- This handshake rule prevents a second capture of a byte the producer has not yet withdrawn. The producer drops valid in response to ready falling.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, HOLD.
  - IDLE: txd=1, ready=1. Accept -> START.
  - START: txd=0 for CLK_DIV cycles -> DATA.
  - DATA: txd=shift[0], LSB first. Each bit is held CLK_DIV cycles, then the register shifts right and the bit index increments. After bit 7 completes -> PARITY if the feature is enabled, else STOP.
  - STOP: txd=1 for STOP_BITS*CLK_DIV cycles. On completion: valid=0 -> IDLE, and ready=1 on the next cycle; valid=1 -> HOLD.
  - HOLD: txd=1, ready=0. When valid=0 -> IDLE.
- Baud counter:
  - width $clog2(CLK_DIV), counts 0..CLK_DIV-1;
  - reloads to 0 on every bit boundary;
  - held at 0 in IDLE and HOLD.
- Frame length from the first txd low cycle to the end of the stop bit(s): (10 + STOP_BITS - 1) * CLK_DIV cycles, plus CLK_DIV if parity is enabled.
- Minimum gap between frames: one cycle of ready=1 in IDLE (back-to-back producer).
- data and valid changes outside the accept cycle have no effect on the frame in flight.
- txd is a registered output (no glitches). ready is registered.
- Reset mid-frame: txd=1 and ready=1 immediately (async); the partial frame is abandoned and nothing is retransmitted.
- valid rising in the same cycle reset deasserts: not accepted until the first edge after reset release.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state follows DATA. txd = XOR of the 8 latched data bits (even parity), held CLK_DIV cycles, then STOP. Parity is computed at accept time and held in a 1-bit register.
- Undefined: no PARITY state and no parity register; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, HOLD=5), 3-bit state type;
  - UART_IDLE_LEVEL=1.
- Sub-module uart_baud_tick (shared later with uart_rx):
  - counter of CLK_DIV, enable input, synchronous clear;
  - one-cycle tick output at each bit boundary.
- uart_tx instantiates one uart_baud_tick.

Test Plan (CLK_DIV=4, STOP_BITS=1 unless noted):
- Reset, then data=0x61, valid=1 -> ready falls the cycle after accept. txd reads 0,1,0,0,0,0,1,1,0,1, each held 4 cycles (40 cycles total), then ready=1 after valid drops.
- Chargen-style producer: valid drops after ready falls, 26 bytes 'a'..'z' -> receiver model decodes exactly a..z in order, no duplicates, with one IDLE cycle between frames.
- valid held high through the end of a frame -> block stays in HOLD with ready=0 and txd=1. No second frame until valid is low for one cycle.
- Assert rst during data bit 3 of 0xFF -> txd=1 and ready=1 within the same cycle (async). The next byte 0x55 transmits as a clean complete frame.
- STOP_BITS=2, data=0x00 -> txd low for 36 cycles (start + 8 data), then high for 8 cycles before ready returns.
- UART_TX_PARITY_EN defined -> data=0x07 gives parity bit 1 and data=0x03 gives parity bit 0, each at cycles 36..39. Frame is 44 cycles.
